// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg
// Shared constants for the GPIO configuration receiver: default frame width,
// bit positions of the decoded pad controls inside the configuration word,
// bit-counter width, and the receiver state encoding.
package gpio_cfg_pkg;

  localparam int CFG_W = 10;
  localparam int CNT_W = 4;

  // Bit positions of the pad controls inside gpio_cfg
  localparam int MGMT_EN = 0;
  localparam int OE_OVR  = 1;
  localparam int IE      = 2;
  localparam int PU      = 3;
  localparam int PD      = 4;
  localparam int SLEW    = 5;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FULL  = 2'd3
  } state_e;

endpackage

// File: rtl/gpio_cfg_shifter.sv
// gpio_cfg_shifter
// Serial shift register, saturating bit counter and registered chain output
// for one pad in the configuration chain.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   clear           - zero shift register and counter (defaults reload)
//   cnt_clr         - zero counter only; shift register contents kept
//   shift_en        - shift one bit in this cycle
//   sdi             - serial data in
//   shreg           - current shift register contents
//   sdo             - registered chain output (old MSB of shreg)
//   full_nxt        - counter will be at full frame length after this edge
module gpio_cfg_shifter #(
  parameter int CFG_W = gpio_cfg_pkg::CFG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cnt_clr,
  input  logic             shift_en,
  input  logic             sdi,
  output logic [CFG_W-1:0] shreg,
  output logic             sdo,
  output logic             full_nxt
);
  import gpio_cfg_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);

  logic [CFG_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sdo_q, sdo_d;

  // clear outranks cnt_clr, which outranks shift; the top guarantees at
  // most the intended one is acted on, but the priority keeps this safe.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sdo_d   = sdo_q;
    if (clear) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (cnt_clr) begin
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[CFG_W-2:0], sdi};
      sdo_d   = shreg_q[CFG_W-1];
      // Saturate at the frame length; pass-through continues beyond it
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      sdo_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sdo_q   <= sdo_d;
    end
  end

  assign shreg    = shreg_q;
  assign sdo      = sdo_q;
  assign full_nxt = (cnt_d == CNT_MAX);

endmodule

// File: rtl/gpio_config_receiver.sv
// gpio_config_receiver
// Per-pad GPIO configuration receiver. After reset it adopts the pad's
// default word, then accepts serial frames shifted through the chain and
// commits a frame to gpio_cfg on serial_load once a full frame is present.
// Ports:
//   serial_clock, resetn      - clock, asynchronous active-low reset
//   gpio_defaults             - static startup configuration word
//   serial_data_in            - chain data bit
//   serial_shift_en           - shift enable
//   serial_load               - commit strobe
//   reload_defaults           - restore gpio_defaults strobe
//   serial_data_out           - registered chain output to next pad
//   gpio_cfg, cfg_valid       - active configuration word and its valid flag
//   load_done, load_err       - one-cycle commit / incomplete-frame pulses
//   mgmt_ena..slow_slew       - pad controls decoded from gpio_cfg
module gpio_config_receiver #(
  parameter int CFG_W = gpio_cfg_pkg::CFG_W
) (
  input  logic             serial_clock,
  input  logic             resetn,
  input  logic [CFG_W-1:0] gpio_defaults,
  input  logic             serial_data_in,
  input  logic             serial_shift_en,
  input  logic             serial_load,
  input  logic             reload_defaults,
  output logic             serial_data_out,
  output logic [CFG_W-1:0] gpio_cfg,
  output logic             cfg_valid,
  output logic             load_done,
  output logic             load_err,
  output logic             mgmt_ena,
  output logic             oe_ovr,
  output logic             inp_ena,
  output logic             pull_up,
  output logic             pull_down,
  output logic             slow_slew
);
  import gpio_cfg_pkg::*;

  state_e           state_q, state_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             sh_clear, sh_cnt_clr, sh_shift, sh_full_nxt;
  logic [CFG_W-1:0] sh_reg;

  gpio_cfg_shifter #(.CFG_W(CFG_W)) u_shifter (
    .clk      (serial_clock),
    .rst_n    (resetn),
    .clear    (sh_clear),
    .cnt_clr  (sh_cnt_clr),
    .shift_en (sh_shift),
    .sdi      (serial_data_in),
    .shreg    (sh_reg),
    .sdo      (serial_data_out),
    .full_nxt (sh_full_nxt)
  );

  // Priority: INIT exit, then reload_defaults, then serial_load, then shift.
  // A load in the same cycle as a shift commits the pre-shift frame and
  // suppresses the shift.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sh_clear   = 1'b0;
    sh_cnt_clr = 1'b0;
    sh_shift   = 1'b0;
    if (state_q == ST_INIT) begin
      cfg_d   = gpio_defaults;
      valid_d = 1'b1;
      state_d = ST_IDLE;
    end else if (reload_defaults) begin
      cfg_d    = gpio_defaults;
      sh_clear = 1'b1;
      state_d  = ST_IDLE;
    end else if (serial_load) begin
      sh_cnt_clr = 1'b1;
      state_d    = ST_IDLE;
      if (state_q == ST_FULL) begin
        cfg_d  = sh_reg;
        done_d = 1'b1;
      end else begin
        // Incomplete frame: keep shreg so the host may inspect/continue
        err_d = 1'b1;
      end
    end else if (serial_shift_en) begin
      sh_shift = 1'b1;
      state_d  = sh_full_nxt ? ST_FULL : ST_SHIFT;
    end
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_INIT;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign gpio_cfg  = cfg_q;
  assign cfg_valid = valid_q;
  assign load_done = done_q;
  assign load_err  = err_q;

  assign mgmt_ena  = cfg_q[MGMT_EN];
  assign oe_ovr    = cfg_q[OE_OVR];
  assign inp_ena   = cfg_q[IE];
  assign pull_up   = cfg_q[PU];
  assign pull_down = cfg_q[PD];
  assign slow_slew = cfg_q[SLEW];

endmodule

// File: tb/tb_gpio_config_receiver.sv
module tb_gpio_config_receiver;
  import gpio_cfg_pkg::*;

  localparam int W = 10;

  logic         serial_clock;
  logic         resetn;
  logic [W-1:0] gpio_defaults;
  logic         serial_data_in, serial_shift_en, serial_load, reload_defaults;
  logic         serial_data_out;
  logic [W-1:0] gpio_cfg;
  logic         cfg_valid, load_done, load_err;
  logic         mgmt_ena, oe_ovr, inp_ena, pull_up, pull_down, slow_slew;

  gpio_config_receiver #(.CFG_W(W)) dut (
    .serial_clock    (serial_clock),
    .resetn          (resetn),
    .gpio_defaults   (gpio_defaults),
    .serial_data_in  (serial_data_in),
    .serial_shift_en (serial_shift_en),
    .serial_load     (serial_load),
    .reload_defaults (reload_defaults),
    .serial_data_out (serial_data_out),
    .gpio_cfg        (gpio_cfg),
    .cfg_valid       (cfg_valid),
    .load_done       (load_done),
    .load_err        (load_err),
    .mgmt_ena        (mgmt_ena),
    .oe_ovr          (oe_ovr),
    .inp_ena         (inp_ena),
    .pull_up         (pull_up),
    .pull_down       (pull_down),
    .slow_slew       (slow_slew)
  );

  initial serial_clock = 1'b0;
  always #5 serial_clock = ~serial_clock;

  typedef struct {
    logic         sdo;
    logic [W-1:0] cfg;
    logic         valid;
    logic         done;
    logic         err;
    logic [3:0]   cnt;
    state_e       st;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [W-1:0] m_shreg;
  logic [W-1:0] m_cfg;
  logic [3:0]   m_cnt;
  logic         m_valid, m_sdo;
  state_e       m_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_shreg = '0; m_cfg = '0; m_cnt = '0;
    m_valid = 1'b0; m_sdo = 1'b0; m_st = ST_INIT;
  endtask

  // Drive one cycle, push the expected outcome, then pop and compare after
  // the edge. Called at posedge+1 so inputs settle well before the edge.
  task automatic step(input logic sdi, input logic sh, input logic ld, input logic rl);
    exp_t e;
    serial_data_in  = sdi;
    serial_shift_en = sh;
    serial_load     = ld;
    reload_defaults = rl;
    e.done = 1'b0;
    e.err  = 1'b0;
    if (m_st == ST_INIT) begin
      m_cfg = gpio_defaults; m_valid = 1'b1; m_st = ST_IDLE;
    end else if (rl) begin
      m_cfg = gpio_defaults; m_shreg = '0; m_cnt = '0; m_st = ST_IDLE;
    end else if (ld) begin
      if (m_st == ST_FULL) begin m_cfg = m_shreg; e.done = 1'b1; end
      else e.err = 1'b1;
      m_cnt = '0; m_st = ST_IDLE;
    end else if (sh) begin
      m_sdo   = m_shreg[W-1];
      m_shreg = {m_shreg[W-2:0], sdi};
      if (m_cnt < 4'(W)) m_cnt++;
      m_st = (m_cnt == 4'(W)) ? ST_FULL : ST_SHIFT;
    end
    e.sdo = m_sdo; e.cfg = m_cfg; e.valid = m_valid; e.cnt = m_cnt; e.st = m_st;
    sb.push_back(e);
    @(posedge serial_clock); #1;
    e = sb.pop_front();
    chk("sdo",   32'(serial_data_out), 32'(e.sdo));
    chk("cfg",   32'(gpio_cfg),        32'(e.cfg));
    chk("valid", 32'(cfg_valid),       32'(e.valid));
    chk("done",  32'(load_done),       32'(e.done));
    chk("err",   32'(load_err),        32'(e.err));
    chk("cnt",   32'(dut.u_shifter.cnt_q), 32'(e.cnt));
    chk("state", 32'(dut.state_q),     32'(e.st));
    chk("decode", 32'({slow_slew, pull_down, pull_up, inp_ena, oe_ovr, mgmt_ena}),
        32'(e.cfg[5:0]));
  endtask

  task automatic shift_word(input logic [W-1:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cfg"},   32'(gpio_cfg), 32'h0);
    chk({tag, "_ctl"},   32'({serial_data_out, cfg_valid, load_done, load_err,
                              slow_slew, pull_down, pull_up, inp_ena, oe_ovr, mgmt_ena}), 32'h0);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(ST_INIT));
    chk({tag, "_cnt"},   32'(dut.u_shifter.cnt_q), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] frame;
    int err_seen;
    resetn          = 1'b0;
    gpio_defaults   = 10'h007;
    serial_data_in  = 1'b0;
    serial_shift_en = 1'b0;
    serial_load     = 1'b0;
    reload_defaults = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge serial_clock);
    #1;
    check_all_zero("rst");
    resetn = 1'b1;

    // INIT exit: defaults adopted one edge after release
    step(0, 0, 0, 0);
    chk("init_cfg", 32'(gpio_cfg), 32'h007);
    chk("init_en",  32'({mgmt_ena, oe_ovr, inp_ena, cfg_valid}), 32'hF);

    // Full frame 10'h21A MSB-first, then commit
    frame = 10'h21A;
    shift_word(frame, W);
    step(0, 0, 1, 0);
    chk("load_cfg", 32'(gpio_cfg), 32'h21A);
    chk("load_pu_slew", 32'({pull_up, slow_slew}), 32'h2);
    step(0, 0, 0, 0);
    chk("done_once", 32'(load_done), 32'h0);

    // Short frame: 6 bits then load -> error, cfg unchanged
    frame = 10'h02D;
    shift_word(frame, 6);
    step(0, 0, 1, 0);
    chk("short_err", 32'(load_err), 32'h1);
    chk("short_cfg", 32'(gpio_cfg), 32'h21A);
    step(0, 0, 0, 0);

    // Load and shift together in FULL: pre-shift frame committed
    frame = 10'h155;
    shift_word(frame, W);
    step(1, 1, 1, 0);
    chk("ldsh_cfg", 32'(gpio_cfg), 32'h155);

    // Fill with ones, then 13 more shifts of zeros: pass-through in FULL
    frame = 10'h3FF;
    shift_word(frame, W);
    for (int i = 0; i < 13; i++) step(0, 1, 0, 0);
    chk("full_cnt",   32'(dut.u_shifter.cnt_q), 32'd10);
    chk("full_state", 32'(dut.state_q), 32'(ST_FULL));

    // reload_defaults beats serial_load in FULL
    step(0, 0, 1, 1);
    chk("rl_cfg",   32'(gpio_cfg), 32'h007);
    chk("rl_pulse", 32'({load_done, load_err}), 32'h0);
    chk("rl_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Reset mid-frame after 5 bits
    frame = 10'h01B;
    shift_word(frame, 5);
    #2 resetn = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge serial_clock); #1;
    resetn = 1'b1;
    step(0, 0, 0, 0);
    chk("rerun_cfg", 32'(gpio_cfg), 32'h007);
    chk("rerun_cnt", 32'(dut.u_shifter.cnt_q), 32'h0);

    // Random traffic through the scoreboard
    err_seen = 0;
    for (int i = 0; i < 300; i++) begin
      logic sdi, sh, ld, rl;
      sdi = 1'($urandom_range(0, 1));
      sh  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 13) == 0);
      rl  = ($urandom_range(0, 59) == 0);
      step(sdi, sh, ld, rl);
      if (load_err) err_seen++;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gpio_config_receiver.md
GPIO_CONFIG_RECEIVER -- requirements
Module: gpio_config_receiver

Interface
REQ-001 The block SHALL have parameter CFG_W, default 10, giving the GPIO configuration word width.
REQ-002 The block SHALL have port serial_clock, input, 1, the single clock; every flop is on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port gpio_defaults, input, CFG_W, the pad startup word from the defaults block; it is static after power-up.
REQ-005 The block SHALL have port serial_data_in, input, 1, the chain data bit, sampled when serial_shift_en=1.
REQ-006 The block SHALL have port serial_shift_en, input, 1, the shift enable.
REQ-007 The block SHALL have port serial_load, input, 1, a one-cycle strobe that commits the shifted frame.
REQ-008 The block SHALL have port reload_defaults, input, 1, a one-cycle strobe that restores gpio_defaults.
REQ-009 The block SHALL have port serial_data_out, output, 1, the registered chain output to the next pad.
REQ-010 The block SHALL have port gpio_cfg, output, CFG_W, the active configuration word.
REQ-011 The block SHALL have port cfg_valid, output, 1, which is high once gpio_cfg holds defaults or a committed frame.
REQ-012 The block SHALL have port load_done, output, 1, a one-cycle pulse when a frame is committed.
REQ-013 The block SHALL have port load_err, output, 1, a one-cycle pulse when serial_load arrives with an incomplete frame.
REQ-014 The block SHALL have ports mgmt_ena, oe_ovr, inp_ena, pull_up, pull_down and slow_slew, each output, 1, decoded from gpio_cfg bits 0, 1, 2, 3, 4 and 5.

Function
REQ-015 The block SHALL implement the states INIT, IDLE, SHIFT and FULL.
REQ-016 In INIT, the first clock edge SHALL load gpio_cfg with gpio_defaults, set cfg_valid=1 and enter IDLE, with all other inputs ignored.
REQ-017 In IDLE, SHIFT or FULL, while serial_shift_en=1, shreg SHALL shift as {shreg[CFG_W-2:0], serial_data_in} and serial_data_out SHALL take the old shreg[CFG_W-1].
REQ-018 A 4-bit bit counter SHALL increment per shift and saturate at CFG_W, moving IDLE->SHIFT on the first bit and SHIFT->FULL at count==CFG_W.
REQ-019 In FULL, further shifts SHALL continue pass-through, with the counter held at CFG_W and the state remaining FULL.
REQ-020 On serial_load in FULL, gpio_cfg SHALL take shreg at the next edge, load_done SHALL pulse in that same cycle, the counter SHALL clear and the state SHALL return to IDLE.
REQ-021 On serial_load in IDLE or SHIFT, load_err SHALL pulse, gpio_cfg SHALL be unchanged, the counter SHALL clear, shreg SHALL be retained and the state SHALL return to IDLE.
REQ-022 When serial_load and serial_shift_en are both high, the load SHALL use the pre-shift shreg and no shift SHALL occur that cycle.
REQ-023 reload_defaults SHALL have highest priority outside INIT: gpio_cfg<=gpio_defaults, shreg<=0, counter<=0, state<=IDLE, with no load_done or load_err pulse and no shift.
REQ-024 The decoded outputs SHALL be combinational from gpio_cfg, adding no latency beyond the gpio_cfg register.
REQ-025 gpio_cfg SHALL change only on INIT exit, on a committed load or on reload_defaults.

Reset
REQ-026 While resetn=0, the block SHALL hold state=INIT, gpio_cfg=0, shreg=0, counter=0, serial_data_out=0, cfg_valid=0, load_done=0 and load_err=0.
REQ-027 Reset assertion mid-shift or mid-load SHALL discard the partial frame, and after release the block SHALL re-run INIT.
REQ-028 Reset deassertion SHALL be synchronized externally, and the block SHALL add no reset synchronizer.

Structure
REQ-029 The shared package gpio_cfg_pkg SHALL hold CFG_W, the bit-index constants (MGMT_EN=0, OE_OVR=1, IE=2, PU=3, PD=4, SLEW=5) and the state enum.
REQ-030 The shift register, bit counter and serial_data_out flop SHALL be one sub-module, gpio_cfg_shifter, and the FSM and config register SHALL be the top level.

Verification
REQ-031 A bench SHALL apply gpio_defaults=10'h007 and release reset, and SHALL check at one edge after release: gpio_cfg=10'h007, cfg_valid=1, mgmt_ena=oe_ovr=inp_ena=1.
REQ-032 A bench SHALL shift 10 bits MSB-first forming 10'h21A and then pulse serial_load, and SHALL check that gpio_cfg=10'h21A the next edge, load_done pulses once, pull_up=1 and slow_slew=0.
REQ-033 A bench SHALL shift 6 bits and then pulse serial_load, and SHALL check that load_err pulses once and gpio_cfg keeps its prior value.
REQ-034 A bench SHALL shift 13 bits after shreg=10'h3FF and SHALL check that serial_data_out emits 1,1,1 delayed one cycle, the counter stays at 10 and the state is FULL.
REQ-035 A bench SHALL assert reload_defaults together with serial_load in FULL and SHALL check that gpio_cfg=gpio_defaults, load_done=0, load_err=0 and the state is IDLE.
REQ-036 A bench SHALL drop resetn after 5 shifted bits and SHALL check that all outputs are 0 immediately, and after release INIT reloads defaults and the counter is 0.
